// File: rtl/rs_pkg.sv
// rs_pkg: shared defaults, width helpers and state encoding for the RS corrector
// Contents: N_DEF/K_DEF/M_DEF defaults, pos_w()/cnt_w() width helpers, state_t IDLE/MSG/PAR
package rs_pkg;
   localparam int N_DEF = 255;
   localparam int K_DEF = 239;
   localparam int M_DEF = 8;
   typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;
   function automatic int pos_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/rs_sym_fifo.sv
// rs_sym_fifo: fall-through synchronous symbol FIFO with full/empty flags
// Ports: clk_in, sys_rst_n (async active-low), wr_en/wr_data (ignored when full),
//        rd_en (ignored when empty), rd_data (head entry, valid while !empty), full, empty
module rs_sym_fifo #(
   parameter int W = 8,
   parameter int D = 2
) (
   input  logic         clk_in,
   input  logic         sys_rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = $clog2(D + 1);
   logic [W-1:0] mem [D];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic do_wr, do_rd;
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;
   assign full = count == CW'(D);
   assign empty = count == '0;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk_in)
      if (do_wr) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk_in or negedge sys_rst_n)
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= (rd_ptr == AW'(D - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
endmodule

// File: rtl/rs_error_corrector.sv
// rs_error_corrector: merges buffered RS codeword symbols with the Chien/Forney error stream
// Ports: clk_in, sys_rst_n (async active-low)
//        rx_valid/rx_data/rx_ready      received symbols, position 0 first, framed by count
//        err_valid/err_flag/err_value/err_fail/err_ready  one correction beat per position
//        out_valid/out_data/out_sof/out_eof/out_fail/out_ready  corrected symbol stream
//        corr_count, frame_done         per-frame correction count and completion pulse
module rs_error_corrector
   import rs_pkg::*;
#(
   parameter int N            = N_DEF,
   parameter int K            = K_DEF,
   parameter int M            = M_DEF,
   parameter int DEPTH        = 2,
   parameter bit STRIP_PARITY = 1'b1
) (
   input  logic                 clk_in,
   input  logic                 sys_rst_n,
   input  logic                 rx_valid,
   input  logic [M-1:0]         rx_data,
   output logic                 rx_ready,
   input  logic                 err_valid,
   input  logic                 err_flag,
   input  logic [M-1:0]         err_value,
   input  logic                 err_fail,
   output logic                 err_ready,
   output logic                 out_valid,
   output logic [M-1:0]         out_data,
   output logic                 out_sof,
   output logic                 out_eof,
   output logic                 out_fail,
   input  logic                 out_ready,
   output logic [cnt_w(N)-1:0]  corr_count,
   output logic                 frame_done
);
   localparam int POS_W = pos_w(N);
   localparam int CNT_W = cnt_w(N);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(N - 1);
   localparam logic [POS_W-1:0] LAST_MSG = POS_W'(K - 1);
   localparam logic [POS_W-1:0] LAST_EMIT = STRIP_PARITY ? LAST_MSG : LAST_POS;
   state_t state, state_nx;
   logic [POS_W-1:0] pos;
   logic [CNT_W-1:0] cnt, cnt_base, cnt_nx;
   logic [M-1:0] fifo_data, corr_data;
   logic fifo_full, fifo_empty, rst_done;
   logic frame_fail, cur_fail, apply, drop, fire, slot_free, first, last;
   // rst_done keeps rx_ready low while reset is asserted and for the release cycle
   assign rx_ready = rst_done & ~fifo_full;
   rs_sym_fifo #(.W(M), .D(DEPTH * N)) u_fifo (
      .clk_in    (clk_in),
      .sys_rst_n (sys_rst_n),
      .wr_en     (rx_valid & rx_ready),
      .wr_data   (rx_data),
      .rd_en     (fire),
      .rd_data   (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
   always_ff @(posedge clk_in or negedge sys_rst_n)
      if (!sys_rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (fire)
         state_nx = (state == PAR) ? (last ? IDLE : PAR) : ((pos == LAST_MSG) ? PAR : MSG);
   end
   // Stripped parity beats need no output slot, so they drain even under backpressure.
   // On the position-0 beat the frame's fail flag and count come straight from the beat.
   always_comb begin
      slot_free = ~out_valid | out_ready;
      drop = STRIP_PARITY && state == PAR;
      err_ready = ~fifo_empty & (slot_free | drop);
      fire = err_valid & err_ready;
      first = pos == '0;
      last = pos == LAST_POS;
      cur_fail = first ? err_fail : frame_fail;
      apply = err_flag & ~cur_fail;
      corr_data = apply ? fifo_data ^ err_value : fifo_data;
      cnt_base = first ? '0 : cnt;
      cnt_nx = (apply && cnt_base != CNT_W'(N)) ? cnt_base + 1'b1 : cnt_base;
   end
   always_ff @(posedge clk_in or negedge sys_rst_n)
      if (!sys_rst_n) begin
         rst_done <= 1'b0;
         pos <= '0;
         cnt <= '0;
         frame_fail <= 1'b0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_sof <= 1'b0;
         out_eof <= 1'b0;
         out_fail <= 1'b0;
         corr_count <= '0;
         frame_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         frame_done <= fire & last;
         if (fire) begin
            pos <= last ? '0 : pos + 1'b1;
            cnt <= cnt_nx;
            frame_fail <= cur_fail;
         end
         if (fire & last) corr_count <= cur_fail ? '0 : cnt_nx;
         if (fire & ~drop) begin
            out_valid <= 1'b1;
            out_data <= corr_data;
            out_sof <= first;
            out_eof <= pos == LAST_EMIT;
            out_fail <= cur_fail;
         end else if (out_ready) out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_rs_error_corrector.sv
// tb_rs_error_corrector: directed bench for the RS corrector (strip and no-strip instances)
module tb_rs_error_corrector;
   localparam int N = 255;
   localparam int K = 239;
   typedef struct {
      int         base;
      bit         fail;
      int         f0;
      logic [7:0] v0;
      int         f1;
      logic [7:0] v1;
   } frame_t;

   logic clk_in = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 clk_in = ~clk_in;

   logic rx_valid_a, rx_ready_a, err_valid_a, err_flag_a, err_fail_a, err_ready_a;
   logic out_valid_a, out_sof_a, out_eof_a, out_fail_a, out_ready_a, frame_done_a;
   logic [7:0] rx_data_a, err_value_a, out_data_a, corr_count_a;
   logic rx_valid_b, rx_ready_b, err_valid_b, err_flag_b, err_fail_b, err_ready_b;
   logic out_valid_b, out_sof_b, out_eof_b, out_fail_b, out_ready_b, frame_done_b;
   logic [7:0] rx_data_b, err_value_b, out_data_b, corr_count_b;

   rs_error_corrector #(.N(N), .K(K), .M(8), .DEPTH(2), .STRIP_PARITY(1'b1)) u_dut_a (
      .clk_in(clk_in), .sys_rst_n(sys_rst_n),
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
      .err_valid(err_valid_a), .err_flag(err_flag_a), .err_value(err_value_a),
      .err_fail(err_fail_a), .err_ready(err_ready_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_sof(out_sof_a), .out_eof(out_eof_a),
      .out_fail(out_fail_a), .out_ready(out_ready_a),
      .corr_count(corr_count_a), .frame_done(frame_done_a)
   );
   rs_error_corrector #(.N(N), .K(K), .M(8), .DEPTH(2), .STRIP_PARITY(1'b0)) u_dut_b (
      .clk_in(clk_in), .sys_rst_n(sys_rst_n),
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
      .err_valid(err_valid_b), .err_flag(err_flag_b), .err_value(err_value_b),
      .err_fail(err_fail_b), .err_ready(err_ready_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_sof(out_sof_b), .out_eof(out_eof_b),
      .out_fail(out_fail_b), .out_ready(out_ready_b),
      .corr_count(corr_count_b), .frame_done(frame_done_b)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] rx_q_a[$], rx_q_b[$];
   logic [9:0] err_q_a[$], err_q_b[$];
   logic [10:0] exp_q_a[$], exp_q_b[$];
   int cnt_q_a[$], cnt_q_b[$];
   bit rx_en_a = 0, err_en_a = 0, rnd_a = 0, rx_en_b = 0, err_en_b = 0, rnd_b = 0;
   int rx_fires_a = 0, err_fires_a = 0, done_a = 0, done_b = 0;
   int n_got_a = 0, n_got_b = 0, fail_n_a = 0;
   logic [7:0] got_a [256];
   logic [7:0] got_b [256];
   bit hold_a = 0, hold_b = 0;
   logic [10:0] hw_a, hw_b;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference behaviour: symbol i of a frame is i+base; flagged positions are XORed
   // with their value unless the frame failed; strip mode keeps positions 0..K-1.
   function automatic logic [7:0] sym_in(input frame_t f, input int i);
      return 8'(i + f.base);
   endfunction
   function automatic bit flag_at(input frame_t f, input int i);
      return i == f.f0 || i == f.f1;
   endfunction
   function automatic logic [7:0] val_at(input frame_t f, input int i);
      return (i == f.f0) ? f.v0 : f.v1;
   endfunction
   function automatic logic [7:0] sym_out(input frame_t f, input int i);
      return (flag_at(f, i) && !f.fail) ? sym_in(f, i) ^ val_at(f, i) : sym_in(f, i);
   endfunction
   function automatic int n_corr(input frame_t f);
      int c = 0;
      if (!f.fail)
         for (int i = 0; i < N; i++) c += int'(flag_at(f, i));
      return c;
   endfunction

   // err_fail toggles on non-zero positions so only the position-0 sample may matter
   task automatic add_frame(input bit b, input frame_t f);
      for (int i = 0; i < N; i++) begin
         logic [9:0] beat;
         beat = {(i == 0) ? f.fail : i[0], flag_at(f, i), val_at(f, i)};
         if (b) begin
            rx_q_b.push_back(sym_in(f, i));
            err_q_b.push_back(beat);
            exp_q_b.push_back({f.fail, i == N - 1, i == 0, sym_out(f, i)});
         end else begin
            rx_q_a.push_back(sym_in(f, i));
            err_q_a.push_back(beat);
            if (i < K) exp_q_a.push_back({f.fail, i == K - 1, i == 0, sym_out(f, i)});
         end
      end
      if (b) cnt_q_b.push_back(n_corr(f));
      else cnt_q_a.push_back(n_corr(f));
   endtask

   function automatic bit busy();
      return exp_q_a.size() != 0 || err_q_a.size() != 0 || cnt_q_a.size() != 0 ||
             exp_q_b.size() != 0 || err_q_b.size() != 0 || cnt_q_b.size() != 0;
   endfunction

   task automatic drain(input int limit);
      int t = 0;
      while (t < limit && busy()) begin
         @(negedge clk_in);
         t++;
      end
      chk("drain_in_time", 32'(t < limit), 1);
   endtask

   task automatic chk_reset_a();
      chk("rst_ready", 32'({rx_ready_a, err_ready_a}), 0);
      chk("rst_out_flags", 32'({out_valid_a, out_sof_a, out_eof_a, out_fail_a, frame_done_a}), 0);
      chk("rst_out_data", 32'(out_data_a), 0);
      chk("rst_corr_count", 32'(corr_count_a), 0);
   endtask

   // Drivers: inputs change 1 time unit after the rising edge, handshakes are judged
   // at the falling edge, when the values the next rising edge will sample are settled.
   initial begin
      {rx_valid_a, rx_data_a, err_valid_a, err_fail_a, err_flag_a, err_value_a, out_ready_a} = '0;
      {rx_valid_b, rx_data_b, err_valid_b, err_fail_b, err_flag_b, err_value_b, out_ready_b} = '0;
      forever begin
         @(posedge clk_in);
         #1;
         rx_valid_a = rx_en_a && rx_q_a.size() > 0;
         rx_data_a = rx_valid_a ? rx_q_a[0] : 8'h00;
         err_valid_a = err_en_a && err_q_a.size() > 0;
         {err_fail_a, err_flag_a, err_value_a} = err_valid_a ? err_q_a[0] : 10'h000;
         out_ready_a = !rnd_a || $urandom_range(0, 1) == 1;
         rx_valid_b = rx_en_b && rx_q_b.size() > 0;
         rx_data_b = rx_valid_b ? rx_q_b[0] : 8'h00;
         err_valid_b = err_en_b && err_q_b.size() > 0;
         {err_fail_b, err_flag_b, err_value_b} = err_valid_b ? err_q_b[0] : 10'h000;
         out_ready_b = !rnd_b || $urandom_range(0, 1) == 1;
         @(negedge clk_in);
         if (rx_valid_a && rx_ready_a) begin
            void'(rx_q_a.pop_front());
            rx_fires_a++;
         end
         if (err_valid_a && err_ready_a) begin
            void'(err_q_a.pop_front());
            err_fires_a++;
         end
         if (rx_valid_b && rx_ready_b) void'(rx_q_b.pop_front());
         if (err_valid_b && err_ready_b) void'(err_q_b.pop_front());
      end
   end

   always @(negedge clk_in) begin
      if (!sys_rst_n) begin
         hold_a = 0;
         hold_b = 0;
      end else begin
         if (hold_a)
            chk("a_stall_hold", 32'({out_valid_a, out_fail_a, out_eof_a, out_sof_a, out_data_a}), 32'({1'b1, hw_a}));
         hold_a = out_valid_a && !out_ready_a;
         hw_a = {out_fail_a, out_eof_a, out_sof_a, out_data_a};
         if (out_valid_a && out_ready_a) begin
            chk("a_out_expected", 32'(exp_q_a.size() > 0), 1);
            if (exp_q_a.size() > 0)
               chk("a_out_word", 32'({out_fail_a, out_eof_a, out_sof_a, out_data_a}), 32'(exp_q_a.pop_front()));
            if (out_sof_a) begin
               n_got_a = 0;
               fail_n_a = 0;
            end
            if (n_got_a < 256) got_a[n_got_a] = out_data_a;
            n_got_a++;
            fail_n_a += int'(out_fail_a);
         end
         if (frame_done_a) begin
            done_a++;
            chk("a_done_expected", 32'(cnt_q_a.size() > 0), 1);
            if (cnt_q_a.size() > 0) chk("a_corr_count", 32'(corr_count_a), cnt_q_a.pop_front());
         end
         if (hold_b)
            chk("b_stall_hold", 32'({out_valid_b, out_fail_b, out_eof_b, out_sof_b, out_data_b}), 32'({1'b1, hw_b}));
         hold_b = out_valid_b && !out_ready_b;
         hw_b = {out_fail_b, out_eof_b, out_sof_b, out_data_b};
         if (out_valid_b && out_ready_b) begin
            chk("b_out_expected", 32'(exp_q_b.size() > 0), 1);
            if (exp_q_b.size() > 0)
               chk("b_out_word", 32'({out_fail_b, out_eof_b, out_sof_b, out_data_b}), 32'(exp_q_b.pop_front()));
            if (out_sof_b) n_got_b = 0;
            if (n_got_b < 256) got_b[n_got_b] = out_data_b;
            n_got_b++;
         end
         if (frame_done_b) begin
            done_b++;
            chk("b_done_expected", 32'(cnt_q_b.size() > 0), 1);
            if (cnt_q_b.size() > 0) chk("b_corr_count", 32'(corr_count_b), cnt_q_b.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_in);
      chk_reset_a();
      chk("b_rst_ready", 32'(rx_ready_b), 0);
      @(posedge clk_in);
      #2 sys_rst_n = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      chk("rx_ready_after_reset", 32'(rx_ready_a), 1);
      // clean codeword 0..254
      rx_en_a = 1;
      err_en_a = 1;
      add_frame(0, '{0, 1'b0, -1, 8'h00, -1, 8'hC3});
      drain(3000);
      chk("t1_count", n_got_a, 239);
      chk("t1_first", 32'(got_a[0]), 32'h00);
      chk("t1_last", 32'(got_a[238]), 32'hEE);
      chk("t1_corr", 32'(corr_count_a), 0);
      chk("t1_done", done_a, 1);
      // flags at 3 and 250 under backpressure
      rnd_a = 1;
      add_frame(0, '{0, 1'b0, 3, 8'h5A, 250, 8'h01});
      drain(3000);
      rnd_a = 0;
      chk("t2_pos3", 32'(got_a[3]), 32'h59);
      chk("t2_pos4", 32'(got_a[4]), 32'h04);
      chk("t2_count", n_got_a, 239);
      chk("t2_corr", 32'(corr_count_a), 2);
      chk("t2_done", done_a, 2);
      // decoder failure: data untouched, fail on every symbol
      add_frame(0, '{0, 1'b1, 3, 8'h5A, 100, 8'h77});
      drain(3000);
      chk("t3_pos3", 32'(got_a[3]), 32'h03);
      chk("t3_pos100", 32'(got_a[100]), 32'h64);
      chk("t3_fail_syms", fail_n_a, 239);
      chk("t3_corr", 32'(corr_count_a), 0);
      // no-strip instance with random backpressure
      rx_en_b = 1;
      err_en_b = 1;
      rnd_b = 1;
      add_frame(1, '{7, 1'b0, 0, 8'hFF, 254, 8'h80});
      drain(4000);
      chk("t4_count", n_got_b, 255);
      chk("t4_pos0", 32'(got_b[0]), 32'hF8);
      chk("t4_pos239", 32'(got_b[239]), 32'hF6);
      chk("t4_pos254", 32'(got_b[254]), 32'h85);
      chk("t4_corr", 32'(corr_count_b), 2);
      chk("t4_done", done_b, 1);
      // buffering: three codewords with the error stream held off
      err_en_a = 0;
      rx_fires_a = 0;
      add_frame(0, '{10, 1'b0, 5, 8'h11, -1, 8'h22});
      add_frame(0, '{20, 1'b0, -1, 8'h00, 240, 8'h33});
      add_frame(0, '{30, 1'b0, 0, 8'h44, 238, 8'h55});
      repeat (600) @(negedge clk_in);
      chk("t5_writes_full", rx_fires_a, 510);
      chk("t5_rx_ready_full", 32'(rx_ready_a), 0);
      err_en_a = 1;
      drain(5000);
      chk("t5_writes_all", rx_fires_a, 765);
      chk("t5_rx_ready_back", 32'(rx_ready_a), 1);
      chk("t5_done", done_a, 6);
      chk("t5_corr", 32'(corr_count_a), 2);
      // reset in the middle of a frame
      err_fires_a = 0;
      add_frame(0, '{50, 1'b0, 3, 8'h0F, -1, 8'h99});
      for (int t = 0; t < 2000 && err_fires_a < 100; t++) @(negedge clk_in);
      chk("t6_reach_pos100", 32'(err_fires_a >= 100), 1);
      @(posedge clk_in);
      #2 sys_rst_n = 1'b0;
      rx_en_a = 0;
      err_en_a = 0;
      rx_q_a.delete();
      err_q_a.delete();
      exp_q_a.delete();
      cnt_q_a.delete();
      @(negedge clk_in);
      chk_reset_a();
      @(posedge clk_in);
      #2 sys_rst_n = 1'b1;
      rx_en_a = 1;
      err_en_a = 1;
      add_frame(0, '{0, 1'b0, 3, 8'h5A, -1, 8'h66});
      drain(3000);
      chk("t6_pos3", 32'(got_a[3]), 32'h59);
      chk("t6_count", n_got_a, 239);
      chk("t6_corr", 32'(corr_count_a), 1);
      chk("t6_done", done_a, 7);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/rs_error_corrector.md
# rs_error_corrector

Final stage of the Reed-Solomon decoder: buffers received codeword symbols and merges them, in received order, with the per-symbol error-value stream produced by the Chien/Forney stage, XOR-correcting flagged positions. Generalises the fixed 255/239 serial corrector to any N/K/M and multiple in-flight codewords. Uses valid/ready handshakes on all three streams, optionally strips parity, and reports per-frame failure and correction counts. Sits between the syndrome/Chien/Forney pipeline and the downstream message sink.

## Interface
- N, 255, codeword length in symbols (K < N ≤ 2^M−1)
- K, 239, message symbols per codeword
- M, 8, symbol width
- DEPTH, 2, codewords of receive buffering (≥1)
- STRIP_PARITY, 1, 1 = emit positions 0..K−1 only; 0 = emit all N
- clk_in  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  received symbol valid
- rx_data  in  M  received symbol, position 0 first
- rx_ready  out  1  buffer can accept a symbol
- err_valid  in  1  correction beat valid
- err_flag  in  1  this position is in error
- err_value  in  M  error magnitude (XOR mask)
- err_fail  in  1  decoder failure for the frame; sampled on position-0 beat only
- err_ready  out  1  correction beat accepted
- out_valid  out  1  output symbol valid
- out_data  out  M  corrected symbol
- out_sof / out_eof  out  1  first / last emitted symbol of frame
- out_fail  out  1  frame flagged uncorrectable (held for all frame symbols)
- out_ready  in  1  downstream accepts
- corr_count  out  clog2(N+1)  corrections applied in last completed frame
- frame_done  out  1  one-cycle pulse when a frame's position N−1 is consumed

## Operation
- Receive side: symbol written to FIFO of DEPTH·N entries on rx_valid & rx_ready; rx_ready = !full. No frame markers on input; framing purely by count.
- Beat fire = err_valid & err_ready; each fire pops one FIFO symbol and advances read position pos (0..N−1, wraps to 0 after N−1).
- err_ready = !empty & (emit_slot_free | position is parity with STRIP_PARITY=1); emit_slot_free = !out_valid | out_ready.
- States: IDLE (pos=0, no frame open) → MSG on position-0 fire; MSG → PAR after fire at pos=K−1 (STRIP_PARITY=1 or 0); PAR → IDLE after fire at pos=N−1. K−1 = N−1 not permitted.
- On position-0 fire: frame_fail ← err_fail; running count ← 0.
- Corrected symbol = fifo_data ^ err_value when err_flag & !frame_fail, else fifo_data unchanged. Running count increments per applied correction (including parity positions); count saturates at N.
- Emission: MSG positions always emitted; PAR positions emitted only if STRIP_PARITY=0. out_sof at pos 0; out_eof at K−1 (strip) or N−1.
- At pos=N−1 fire: corr_count ← final count (0 if frame_fail), frame_done pulses.
- err_valid with empty FIFO: stall (err_ready low), no error raised.

## Timing
- Reset values: rx_ready 0 during reset, 1 in first cycle after; err_ready 0; out_valid 0; out_data 0; out_sof/eof/fail 0; corr_count 0; frame_done 0; state IDLE, pos 0, FIFO empty.
- FIFO write → symbol poppable next cycle (1-cycle fall-through latency).
- Fire → out_valid/out_data registered next cycle; frame_done same cycle as the N−1 output register update.
- Output held stable while out_valid & !out_ready; full throughput 1 symbol/cycle with out_ready high.
- Simultaneous write and pop on full FIFO: rx_ready low, so write blocked; on empty, pop blocked.
- Reset asserted mid-frame: all state cleared immediately, buffered symbols discarded, partial frame not emitted.

## Structure
- Shared package rs_pkg: default N/K/M, width helpers (POS_W = clog2(N), CNT_W = clog2(N+1)), state enum IDLE/MSG/PAR.
- Sub-module rs_sym_fifo: synchronous FIFO, parametrised width/depth, full/empty flags, async active-low reset.

## Test plan
- N=255,K=239: stream one codeword 0..254, all err_flag=0 → 239 outputs equal input, out_sof at 0, out_eof at 238, corr_count=0.
- Flags at positions 3 (value 8'h5A) and 250 (8'h01) → output[3]=in^8'h5A, parity not emitted, corr_count=2, frame_done once.
- err_fail=1 on position 0 with flags set → data passes unmodified, out_fail high on all 239 symbols, corr_count=0.
- STRIP_PARITY=0, random out_ready backpressure 50% → all 255 symbols emitted in order, no loss/duplication, out_data stable while stalled.
- DEPTH=2: three back-to-back codewords written while err_valid held low → rx_ready drops after 510 symbols; draining restores it, frames emitted in order.
- Reset pulse at position 100 → outputs return to reset values; next codeword decodes correctly from pos 0.
